// File: rtl/trigger_sequencer.sv
// Capture-cycle sequencer for the comparator trigger path: clear, arm, wait for
// trigger, gate the post-trigger window, flag completion, hold off, re-arm.
module trigger_sequencer #(
  parameter int unsigned POST_W      = 16,
  parameter int unsigned HOLD_W      = 16,
  parameter int unsigned RESET_PULSE = 4
) (
  input  logic              clk,
  input  logic              module_reset,
  input  logic              cmd_arm,
  input  logic              cmd_abort,
  input  logic              cmd_force,
  input  logic              cmd_auto,
  input  logic [POST_W-1:0] post_trig_count,
  input  logic [HOLD_W-1:0] holdoff_count,
  input  logic              triggered,
  output logic              armed,
  output logic              manual_reset,
  output logic              manual_trigger,
  output logic              auto_reset,
  output logic              capture_en,
  output logic              acq_done,
  output logic              busy,
  output logic [2:0]        state
);

  localparam int unsigned RP_W = (RESET_PULSE > 1) ? $clog2(RESET_PULSE) : 1;
  localparam int unsigned PH_W = (POST_W > HOLD_W) ? POST_W : HOLD_W;
  localparam int unsigned CW   = (PH_W > RP_W) ? PH_W : RP_W;
  localparam logic [CW-1:0] RP_LOAD = CW'(RESET_PULSE - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          trig_q, trig_edge;
  logic          mt_nxt, cap_nxt;

  // trig_q tracks triggered in every state, so a level already high when
  // ARMED is entered never looks like a fresh edge.
  assign trig_edge = triggered & ~trig_q;

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    mt_nxt  = 1'b0;
    if (cmd_abort && cur != S_IDLE) begin
      nxt     = S_IDLE;
      cnt_nxt = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (cmd_arm && !cmd_abort) begin
            nxt     = S_CLEAR;
            cnt_nxt = RP_LOAD;
          end
        end
        S_CLEAR: begin
          if (cnt == '0) nxt = S_ARMED;
          else           cnt_nxt = cnt - CW'(1);
        end
        S_ARMED: begin
          if (trig_edge) begin
            nxt     = S_POST;
            cnt_nxt = CW'(post_trig_count);
          end else if (cmd_force) begin
            mt_nxt = 1'b1;
          end
        end
        S_POST: begin
          // The entry cycle already covered the first window cycle.
          if (cnt <= CW'(1)) begin
            nxt     = S_DONE;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_DONE: begin
          nxt     = S_HOLDOFF;
          cnt_nxt = CW'(holdoff_count);
        end
        S_HOLDOFF: begin
          if (cnt == '0) begin
            if (cmd_auto) begin
              nxt     = S_CLEAR;
              cnt_nxt = RP_LOAD;
            end else begin
              nxt = S_IDLE;
            end
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        default: begin
          nxt     = S_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
    cap_nxt = (nxt == S_POST) && (cnt_nxt != '0);
  end

  always_ff @(posedge clk or posedge module_reset) begin
    if (module_reset) begin
      cur            <= S_IDLE;
      cnt            <= '0;
      trig_q         <= 1'b0;
      armed          <= 1'b0;
      manual_reset   <= 1'b0;
      manual_trigger <= 1'b0;
      auto_reset     <= 1'b0;
      capture_en     <= 1'b0;
      acq_done       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      cur            <= nxt;
      cnt            <= cnt_nxt;
      trig_q         <= triggered;
      armed          <= (nxt == S_ARMED);
      manual_reset   <= (nxt == S_CLEAR);
      manual_trigger <= mt_nxt;
      auto_reset     <= cmd_auto;
      capture_en     <= cap_nxt;
      acq_done       <= (nxt == S_DONE);
      busy           <= (nxt != S_IDLE);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Randomized bench for trigger_sequencer; expected waveforms are built from
// the documented edge-relative timing of each acquisition.
module tb_trigger_sequencer;
  localparam int RP = 4;
  localparam int SZ = 16384;

  logic        clk = 1'b0;
  logic        module_reset, cmd_arm, cmd_abort, cmd_force, cmd_auto, triggered;
  logic [15:0] post_trig_count, holdoff_count;
  logic        armed, manual_reset, manual_trigger, auto_reset, capture_en, acq_done, busy;
  logic [2:0]  state;

  always #5 clk = ~clk;

  trigger_sequencer #(.POST_W(16), .HOLD_W(16), .RESET_PULSE(RP)) dut (
    .clk(clk), .module_reset(module_reset), .cmd_arm(cmd_arm), .cmd_abort(cmd_abort),
    .cmd_force(cmd_force), .cmd_auto(cmd_auto), .post_trig_count(post_trig_count),
    .holdoff_count(holdoff_count), .triggered(triggered), .armed(armed),
    .manual_reset(manual_reset), .manual_trigger(manual_trigger), .auto_reset(auto_reset),
    .capture_en(capture_en), .acq_done(acq_done), .busy(busy), .state(state)
  );

  int ec;
  int checks, passes;
  logic [9:0] lg [0:SZ-1];
  bit         auto_e [0:SZ-1];
  bit         e_mr [0:SZ-1];
  bit         e_ar [0:SZ-1];
  bit         e_mt [0:SZ-1];
  bit         e_cap[0:SZ-1];
  bit         e_done[0:SZ-1];
  logic [2:0] e_st [0:SZ-1];

  // lg[s] holds outputs as seen by edge s (i.e. set at edge s-1).
  task automatic tick();
    @(posedge clk);
    ec++;
    auto_e[ec] = cmd_auto;
    #1;
    lg[ec+1] = {state, armed, manual_reset, manual_trigger, auto_reset, capture_en, acq_done, busy};
  endtask

  task automatic run_to(input int e);
    while (ec < e) tick();
  endtask

  function automatic logic [9:0] exp_vec(input int s);
    return {e_st[s], e_ar[s], e_mr[s], e_mt[s], auto_e[s-1], e_cap[s], e_done[s], (e_st[s] != 3'd0)};
  endfunction

  task automatic exp_clear(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) begin
      e_mr[s] = 0; e_ar[s] = 0; e_mt[s] = 0; e_cap[s] = 0; e_done[s] = 0; e_st[s] = 3'd0;
    end
  endtask

  // n: edge where CLEAR is entered, t: edge where the trigger edge is sampled.
  task automatic model_acq(input int n, input int t, input int N, input int H);
    int ne;
    ne = (N == 0) ? 1 : N;
    for (int s = n + 1; s <= n + RP; s++) begin e_st[s] = 3'd1; e_mr[s] = 1; end
    for (int s = n + RP + 1; s <= t; s++) begin e_st[s] = 3'd2; e_ar[s] = 1; end
    for (int s = t + 1; s <= t + ne; s++) begin e_st[s] = 3'd3; e_cap[s] = (N != 0); end
    e_st[t+ne+1] = 3'd4; e_done[t+ne+1] = 1;
    for (int s = t + ne + 2; s <= t + ne + H + 2; s++) e_st[s] = 3'd5;
  endtask

  task automatic test_reset();
    int lo;
    #1;
    checks++;
    if ({state, armed, manual_reset, manual_trigger, auto_reset, capture_en, acq_done, busy} !== 10'd0)
      $display("FAIL reset_init got=%b exp=%b", {state, armed, manual_reset, manual_trigger,
               auto_reset, capture_en, acq_done, busy}, 10'd0);
    else passes++;
    tick(); tick();
    module_reset = 0;
    exp_clear(ec + 1, ec + 40);
    lo = ec + 2;
    cmd_force = 1; tick(); cmd_force = 0;
    cmd_abort = 1; tick(); cmd_abort = 0;
    triggered = 1; tick(); triggered = 0;
    repeat (4) tick();
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL idle_ignore t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_capture(input int N, input int H, input int d);
    int n, t, lo, ne;
    ne = (N == 0) ? 1 : N;
    exp_clear(ec + 1, ec + 600);
    lo = ec + 2;
    post_trig_count = 16'(N); holdoff_count = 16'(H);
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    repeat (RP + d) tick();
    triggered = 1; tick(); t = ec; triggered = 0;
    post_trig_count = 16'($urandom);
    run_to(t + ne + 1);
    holdoff_count = 16'($urandom);
    run_to(t + ne + H + 6);
    model_acq(n, t, N, H);
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s))
        $display("FAIL capture N=%0d H=%0d t=%0d got=%b exp=%b", N, H, s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_held_high();
    int n, t, lo;
    exp_clear(ec + 1, ec + 600);
    lo = ec + 2;
    post_trig_count = 16'd3; holdoff_count = 16'd1;
    triggered = 1;
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 3);
    triggered = 0; tick();
    triggered = 1; tick(); t = ec; triggered = 0;
    run_to(t + 3 + 1 + 6);
    model_acq(n, t, 3, 1);
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL held_high t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_force();
    int n, t, f, lo;
    exp_clear(ec + 1, ec + 600);
    lo = ec + 2;
    post_trig_count = 16'd4; holdoff_count = 16'd2;
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 2);
    cmd_force = 1; tick(); f = ec; cmd_force = 0;
    run_to(f + 2);
    triggered = 1; tick(); t = ec; triggered = 0;
    run_to(t + 12);
    model_acq(n, t, 4, 2);
    e_mt[f+1] = 1;
    // force on the same edge as the trigger edge: no manual_trigger pulse
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 1);
    cmd_force = 1; triggered = 1; tick(); t = ec; cmd_force = 0; triggered = 0;
    run_to(t + 12);
    model_acq(n, t, 4, 2);
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL force t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_auto();
    int n, t, lo, N, H, ne, d;
    N = $urandom_range(1, 6); H = $urandom_range(0, 4); ne = N;
    exp_clear(ec + 1, ec + 900);
    lo = ec + 2;
    post_trig_count = 16'(N); holdoff_count = 16'(H);
    cmd_auto = 1; tick();
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    t = n;
    for (int k = 0; k < 3; k++) begin
      d = $urandom_range(0, 3);
      run_to(n + RP + d);
      triggered = 1; tick(); t = ec; triggered = 0;
      if (k == 2) cmd_auto = 0;
      model_acq(n, t, N, H);
      n = t + ne + H + 2;
    end
    run_to(t + ne + H + 6);
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL auto t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_abort();
    int n, t, a, lo;
    exp_clear(ec + 1, ec + 900);
    lo = ec + 2;
    post_trig_count = 16'd8; holdoff_count = 16'd3;
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 2);
    cmd_abort = 1; tick(); a = ec; cmd_abort = 0;
    model_acq(n, a + 5, 8, 3);
    exp_clear(a + 1, a + 40);
    tick(); triggered = 1; tick(); triggered = 0;
    run_to(a + 6);
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 1);
    triggered = 1; tick(); t = ec; triggered = 0;
    run_to(t + 2);
    cmd_abort = 1; tick(); a = ec; cmd_abort = 0;
    model_acq(n, t, 8, 3);
    exp_clear(a + 1, a + 40);
    run_to(a + 4);
    cmd_arm = 1; cmd_abort = 1; tick(); cmd_arm = 0; cmd_abort = 0;
    repeat (6) tick();
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL abort t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  task automatic test_reset_mid_post();
    int n, t, lo;
    post_trig_count = 16'd20; holdoff_count = 16'd2;
    cmd_arm = 1; tick(); cmd_arm = 0; n = ec;
    run_to(n + RP + 1);
    triggered = 1; tick(); t = ec; triggered = 0;
    run_to(t + 3);
    checks++;
    if (capture_en !== 1'b1) $display("FAIL pre_reset_capture got=%b exp=1", capture_en);
    else passes++;
    #2 module_reset = 1;
    #1;
    checks++;
    if ({state, armed, manual_reset, manual_trigger, auto_reset, capture_en, acq_done, busy} !== 10'd0)
      $display("FAIL reset_async got=%b exp=%b", {state, armed, manual_reset, manual_trigger,
               auto_reset, capture_en, acq_done, busy}, 10'd0);
    else passes++;
    tick();
    module_reset = 0;
    exp_clear(ec + 1, ec + 40);
    lo = ec + 2;
    repeat (5) tick();
    for (int s = lo; s <= ec + 1; s++) begin
      checks++;
      if (lg[s] !== exp_vec(s)) $display("FAIL post_reset_idle t=%0d got=%b exp=%b", s, lg[s], exp_vec(s));
      else passes++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog ec=%0d checks=%0d", ec, checks);
    $fatal(1, "timeout");
  end

  initial begin
    ec = 0; checks = 0; passes = 0;
    module_reset = 1; cmd_arm = 0; cmd_abort = 0; cmd_force = 0; cmd_auto = 0; triggered = 0;
    post_trig_count = '0; holdoff_count = '0;
    test_reset();
    test_capture(8, 5, 5);
    test_capture(1, 0, 0);
    test_capture(0, 2, 1);
    for (int i = 0; i < 4; i++)
      test_capture($urandom_range(1, 20), $urandom_range(0, 6), $urandom_range(0, 5));
    test_held_high();
    test_force();
    test_auto();
    test_abort();
    test_reset_mid_post();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
# trigger_sequencer

Acquisition-side controller for the comparator trigger path: it drives the arm, reset and force inputs of the trigger control block and consumes its triggered output. It sequences one capture cycle: clear latched comparator, arm, wait for trigger, gate a fixed post-trigger capture window, signal completion, hold off, then either idle or re-arm in auto mode. It sits between the host command decoder and the trigger control block; its capture_en gates the ADC sample buffer writes.

## Interface
Parameters:
- POST_W, 16, width of post-trigger sample count
- HOLD_W, 16, width of holdoff count
- RESET_PULSE, 4, cycles manual_reset is held high in CLEAR (≥1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- module_reset  in  1  asynchronous, active-high reset
- cmd_arm  in  1  one-cycle pulse: start acquisition (honoured only in IDLE)
- cmd_abort  in  1  one-cycle pulse: abandon acquisition from any state
- cmd_force  in  1  one-cycle pulse: software trigger request (honoured only in ARMED)
- cmd_auto  in  1  level: continuous re-arm mode
- post_trig_count  in  POST_W  capture window length in cycles
- holdoff_count  in  HOLD_W  dead time after completion in cycles
- triggered  in  1  triggered flag from trigger control, synchronous to clk
- armed  out  1  arm to trigger control
- manual_reset  out  1  comparator/trigger latch clear
- manual_trigger  out  1  one-cycle force-trigger pulse
- auto_reset  out  1  registered copy of cmd_auto
- capture_en  out  1  high during post-trigger window
- acq_done  out  1  one-cycle completion pulse
- busy  out  1  state != IDLE
- state  out  3  debug state code

## Operation
- States/codes: IDLE=0, CLEAR=1, ARMED=2, POST=3, DONE=4, HOLDOFF=5; others unreachable, decode to IDLE.
- All outputs registered. Reset: state IDLE, every output 0, counters 0, trig_q 0.
- IDLE: cmd_arm → CLEAR. Other commands ignored.
- CLEAR: manual_reset=1 for exactly RESET_PULSE cycles, then → ARMED.
- ARMED: armed=1. trig_q <= triggered every cycle; rising edge (triggered=1, trig_q=0) → POST, latching post_trig_count into counter. A level already high on ARMED entry does not trigger.
- cmd_force in ARMED: manual_trigger=1 for one cycle; remain ARMED until trigger control returns the triggered edge. Force coincident with triggered edge: edge wins, no manual_trigger pulse.
- POST: capture_en=1 for exactly latched count cycles, then → DONE. Count 0 → DONE next cycle, capture_en never asserted.
- DONE: acq_done=1 one cycle; → HOLDOFF latching holdoff_count.
- HOLDOFF: count holdoff cycles (0 → skip, one transit cycle); then cmd_auto=1 → CLEAR, else → IDLE. cmd_auto sampled at HOLDOFF exit.
- cmd_abort: highest priority in every non-IDLE state; next cycle IDLE, all outputs 0, no acq_done. Abort and arm same cycle in IDLE: stay IDLE.
- post_trig_count/holdoff_count changes after latch have no effect on current cycle.
- Counters are down-counters, no wrap: max window 2^POST_W−1 cycles.

## Timing
- cmd_arm at edge n → manual_reset high at n+1..n+RESET_PULSE, armed high from n+RESET_PULSE+1.
- Triggered edge sampled at edge t → armed low, capture_en high from t+1, through t+N (N=count).
- acq_done at t+N+1; busy low at t+N+H+3 (H=holdoff, 0 gives t+N+3) in non-auto mode.
- Auto mode: manual_reset re-asserts the cycle after HOLDOFF exit.
- cmd_force at edge f → manual_trigger high exactly cycle f+1.
- auto_reset follows cmd_auto with one cycle latency in all states.

## Test plan
- Reset mid-POST (module_reset asserted asynchronously) → all outputs 0 immediately, state=0.
- Arm with RESET_PULSE=4, triggered edge 10 cycles later, post_trig_count=8, holdoff=5 → manual_reset 4 cycles, capture_en exactly 8 cycles, one acq_done, busy drops after holdoff, state returns 0.
- triggered held high through CLEAR into ARMED → no capture until it drops and rises again.
- cmd_force in ARMED → single manual_trigger cycle; echoed triggered edge 3 cycles later → capture starts; force coincident with edge → no manual_trigger.
- cmd_auto=1, three consecutive triggers → three acq_done pulses, CLEAR re-entered after each holdoff without cmd_arm.
- cmd_abort during ARMED and during POST → IDLE next cycle, capture_en/armed low, no acq_done; post_trig_count=0 → acq_done with zero capture_en cycles.
